// File: rtl/tape_ovl_pkg.sv
// Shared types and constants for the tape status overlay.
// Holds the sequencer state encoding, the default character codes and a saturating subtract.
package tape_ovl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GEAR_L = 3'd1,
    ST_GEAR_R = 3'd2,
    ST_BAR    = 3'd3,
    ST_GAP    = 3'd4
  } seq_state_t;

  localparam logic [7:0] DEF_CH_GEAR_A = 8'h2A;
  localparam logic [7:0] DEF_CH_GEAR_B = 8'h96;
  localparam logic [7:0] DEF_CH_FULL   = 8'h7F;
  localparam logic [7:0] DEF_CH_EMPTY  = 8'hA6;

  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'h00;
  endfunction

endpackage

// File: rtl/tape_status_seq_if.sv
// Character-RAM write port between the status sequencer and the overlay's char RAM (port A).
// wr_ena qualifies wr_addr/wr_data for exactly one cycle; the RAM port always accepts, so there is no ready.
interface tape_status_seq_if #(
  parameter int ADDRW = 12
);
  logic             wr_ena;
  logic [ADDRW-1:0] wr_addr;
  logic [7:0]       wr_data;

  modport master (output wr_ena, wr_addr, wr_data);
  modport slave  (input  wr_ena, wr_addr, wr_data);
endinterface

// File: rtl/tape_status_seq_peak_meter.sv
// Peak-hold level meter: captures the highest sample, holds it for HOLD_FRAMES frames,
// then decays by DECAY per frame. Updates only on frame_tick.
module tape_peak_meter
  import tape_ovl_pkg::*;
#(
  parameter int         HOLD_FRAMES = 30,
  parameter logic [7:0] DECAY       = 8'd2
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] tape_data,
  output logic [7:0] peak_level
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic [HW-1:0] hold;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      peak_level <= 8'h00;
      hold       <= '0;
    end else if (frame_tick) begin
      if (tape_data >= peak_level) begin
        peak_level <= tape_data;
        hold       <= HW'(HOLD_FRAMES);
      end else if (hold != '0) begin
        hold <= hold - HW'(1);
      end else begin
        peak_level <= sat_sub8(peak_level, DECAY);
      end
    end
  end

endmodule

// File: rtl/tape_status_seq.sv
// Tape status overlay updater: tracks tape position into an NSEG-segment progress bar,
// animates two gears, and redraws them into char RAM through a single write port.
module tape_status_seq
  import tape_ovl_pkg::*;
#(
  parameter int         POSW        = 25,
  parameter int         NSEG        = 16,
  parameter int         ADDRW       = 12,
  parameter int         BAR_BASE    = 136,
  parameter int         GEAR_L_ADDR = 331,
  parameter int         GEAR_R_ADDR = 340,
  parameter logic [7:0] CH_GEAR_A   = DEF_CH_GEAR_A,
  parameter logic [7:0] CH_GEAR_B   = DEF_CH_GEAR_B,
  parameter logic [7:0] CH_FULL     = DEF_CH_FULL,
  parameter logic [7:0] CH_EMPTY    = DEF_CH_EMPTY,
  parameter int         HOLD_FRAMES = 30,
  parameter logic [7:0] DECAY       = 8'd2
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [POSW-1:0]       max,
  input  logic [POSW-1:0]       pos,
  input  logic [7:0]            tape_data,
  input  logic                  frame_tick,
  tape_status_seq_if.master     wr,
  output logic [$clog2(NSEG):0] blocks,
  output logic [7:0]            peak_level,
  output logic                  busy,
  output seq_state_t            dbg_state
);

  localparam int SEGW = $clog2(NSEG);
  localparam int BW   = SEGW + 1;

  // ---------------- position tracking ----------------
  logic [POSW-1:0] pos_r;
  logic [POSW-1:0] inc_pos;
  logic [POSW-1:0] increment;
  logic [POSW:0]   inc_next;
  logic            pos_chg;
  logic            pos_fwd;
  logic            pos_rew;
  logic            gear_phase;

  assign increment = max >> SEGW;
  assign pos_chg   = (pos != pos_r);
  assign pos_fwd   = (pos > pos_r);
  assign pos_rew   = (pos < pos_r) || (pos == '0);
  assign inc_next  = {1'b0, inc_pos} + (POSW + 1)'(1);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      pos_r      <= '0;
      inc_pos    <= '0;
      blocks     <= '0;
      gear_phase <= 1'b0;
    end else begin
      pos_r <= pos;
      if (pos_chg) gear_phase <= ~gear_phase;
      // Rewind (or parking at zero) wins over a forward step.
      if (pos_rew) begin
        inc_pos <= '0;
        blocks  <= '0;
      end else if (pos_fwd) begin
        if (inc_next >= {1'b0, increment}) begin
          inc_pos <= '0;
          if (blocks != BW'(NSEG)) blocks <= blocks + BW'(1);
        end else begin
          inc_pos <= inc_next[POSW-1:0];
        end
      end
    end
  end

  // ---------------- redraw sequencer ----------------
  seq_state_t       state, state_nx;
  logic [SEGW-1:0]  seg, seg_nx;
  logic [BW-1:0]    blk_snap;
  logic             gear_snap;
  logic             dirty;
  logic             launch;
  logic             wr_ena_nx;
  logic [ADDRW-1:0] wr_addr_nx;
  logic [7:0]       wr_data_nx;

  function automatic logic [7:0] bar_code(input logic [SEGW-1:0] s, input logic [BW-1:0] n);
    return ({1'b0, s} < n) ? CH_FULL : CH_EMPTY;
  endfunction

  function automatic logic [ADDRW-1:0] bar_addr(input logic [SEGW-1:0] s);
    return ADDRW'(BAR_BASE) + ADDRW'(s);
  endfunction

  // The write strobe is decoded from the next state so the registered
  // outputs line up with the state that owns the write.
  always_comb begin
    state_nx   = state;
    seg_nx     = seg;
    launch     = 1'b0;
    wr_ena_nx  = 1'b0;
    wr_addr_nx = wr.wr_addr;
    wr_data_nx = wr.wr_data;
    case (state)
      ST_IDLE: begin
        if (dirty && ena) begin
          launch     = 1'b1;
          state_nx   = ST_GEAR_L;
          wr_ena_nx  = 1'b1;
          wr_addr_nx = ADDRW'(GEAR_L_ADDR);
          wr_data_nx = gear_phase ? CH_GEAR_A : CH_GEAR_B;
        end
      end
      ST_GEAR_L: begin
        state_nx   = ST_GEAR_R;
        wr_ena_nx  = 1'b1;
        wr_addr_nx = ADDRW'(GEAR_R_ADDR);
        wr_data_nx = gear_snap ? CH_GEAR_B : CH_GEAR_A;
      end
      ST_GEAR_R: begin
        state_nx   = ST_BAR;
        seg_nx     = '0;
        wr_ena_nx  = 1'b1;
        wr_addr_nx = bar_addr('0);
        wr_data_nx = bar_code('0, blk_snap);
      end
      ST_BAR: begin
        if (seg == SEGW'(NSEG - 1)) begin
          state_nx = ST_GAP;
        end else begin
          seg_nx     = seg + SEGW'(1);
          wr_ena_nx  = 1'b1;
          wr_addr_nx = bar_addr(seg + SEGW'(1));
          wr_data_nx = bar_code(seg + SEGW'(1), blk_snap);
        end
      end
      ST_GAP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      seg        <= '0;
      blk_snap   <= '0;
      gear_snap  <= 1'b0;
      dirty      <= 1'b1;
      busy       <= 1'b0;
      wr.wr_ena  <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= 8'h00;
    end else begin
      state      <= state_nx;
      seg        <= seg_nx;
      busy       <= (state_nx != ST_IDLE);
      wr.wr_ena  <= wr_ena_nx;
      wr.wr_addr <= wr_addr_nx;
      wr.wr_data <= wr_data_nx;
      if (launch) begin
        blk_snap  <= blocks;
        gear_snap <= gear_phase;
      end
      // A change in the launch cycle is newer than the snapshot, so it must re-arm.
      if (pos_chg)     dirty <= 1'b1;
      else if (launch) dirty <= 1'b0;
    end
  end

  assign dbg_state = state;

  // ---------------- peak meter ----------------
  tape_peak_meter #(
    .HOLD_FRAMES (HOLD_FRAMES),
    .DECAY       (DECAY)
  ) u_peak (
    .i_clk      (i_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .tape_data  (tape_data),
    .peak_level (peak_level)
  );

endmodule

// File: tb/tb_tape_status_seq.sv
// Bench for tape_status_seq: table vectors, hand-written timing sequences and a random
// walk, all checked against a spec-level model and a shadow copy of the char RAM.
module tb_tape_status_seq;
  import tape_ovl_pkg::*;

  localparam int NSEG   = 16;
  localparam int GL     = 331;
  localparam int GR     = 340;
  localparam int BBASE  = 136;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        reset = 1'b1;
  logic        ena = 1'b1;
  logic [24:0] max = 25'd160;
  logic [24:0] pos = 25'd0;
  logic [7:0]  tape_data = 8'd0;
  logic        frame_tick = 1'b0;
  logic [4:0]  blocks;
  logic [7:0]  peak_level;
  logic        busy;
  seq_state_t  dbg_state;

  always #5 i_clk = ~i_clk;

  tape_status_seq_if #(.ADDRW(12)) wr_if ();

  tape_status_seq dut (
    .i_clk      (i_clk),
    .reset      (reset),
    .ena        (ena),
    .max        (max),
    .pos        (pos),
    .tape_data  (tape_data),
    .frame_tick (frame_tick),
    .wr         (wr_if),
    .blocks     (blocks),
    .peak_level (peak_level),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge i_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  // ---------------- reference model ----------------
  int m_pos_r, m_inc, m_blocks, m_incr, m_peak, m_hold;
  bit m_gear;

  always @(posedge i_clk) begin
    if (reset) begin
      m_pos_r = 0; m_inc = 0; m_blocks = 0; m_gear = 0;
      m_peak = 0; m_hold = 0;
    end else begin
      m_incr = int'(max) / NSEG;
      if (int'(pos) != m_pos_r) m_gear = ~m_gear;
      if (int'(pos) == 0 || int'(pos) < m_pos_r) begin
        m_inc = 0; m_blocks = 0;
      end else if (int'(pos) > m_pos_r) begin
        if (m_inc + 1 >= m_incr) begin
          m_inc = 0;
          m_blocks = (m_blocks + 1 > NSEG) ? NSEG : m_blocks + 1;
        end else begin
          m_inc = m_inc + 1;
        end
      end
      m_pos_r = int'(pos);
      if (frame_tick) begin
        if (int'(tape_data) >= m_peak) begin
          m_peak = int'(tape_data); m_hold = 30;
        end else if (m_hold > 0) begin
          m_hold = m_hold - 1;
        end else begin
          m_peak = (m_peak > 2) ? m_peak - 2 : 0;
        end
      end
    end
  end

  // ---------------- write monitor / shadow RAM ----------------
  logic [7:0] shadow [0:4095];
  int         seq_start[$];
  int         seq_cnt = 0;
  int         run_len = 0;
  logic [7:0] first_gear;
  logic [7:0] exp_q[$];

  always @(negedge i_clk) begin
    if (reset) begin
      run_len = 0;
    end else if (wr_if.wr_ena) begin
      if (run_len == 0) begin
        seq_start.push_back(cyc);
        seq_cnt++;
        first_gear = wr_if.wr_data;
      end
      shadow[wr_if.wr_addr] = wr_if.wr_data;
      chk("wr_addr_order", 32'(wr_if.wr_addr),
          (run_len == 0) ? GL : (run_len == 1) ? GR : BBASE + run_len - 2);
      if (run_len == 1)
        chk("gear_r_opposite", 32'(wr_if.wr_data), (first_gear == 8'h2A) ? 32'h96 : 32'h2A);
      run_len++;
    end else if (run_len != 0) begin
      chk("burst_len", run_len, NSEG + 2);
      run_len = 0;
    end
  end

  task automatic check_image(input string tag);
    exp_q.delete();
    exp_q.push_back(m_gear ? 8'h2A : 8'h96);
    exp_q.push_back(m_gear ? 8'h96 : 8'h2A);
    for (int i = 0; i < NSEG; i++) exp_q.push_back((i < m_blocks) ? 8'h7F : 8'hA6);
    sample();
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_blocks"}, 32'(blocks), m_blocks);
    chk({tag, "_gear_l"}, 32'(shadow[GL]), 32'(exp_q.pop_front()));
    chk({tag, "_gear_r"}, 32'(shadow[GR]), 32'(exp_q.pop_front()));
    for (int i = 0; i < NSEG; i++)
      chk({tag, "_bar"}, 32'(shadow[BBASE + i]), 32'(exp_q.pop_front()));
  endtask

  task automatic tick(input logic [7:0] d);
    tape_data  = d;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    tape_data  = 8'd0;
    sample();
  endtask

  typedef struct {
    int mx;
    int p;
    int exp_blk;
  } vec_t;
  vec_t vt[$];

  // ---------------- stimulus ----------------
  initial begin
    int c, n0, r;
    int pv;

    // reset state
    step(3);
    sample();
    chk("rst_wr_ena", 32'(wr_if.wr_ena), 0);
    chk("rst_wr_addr", 32'(wr_if.wr_addr), 0);
    chk("rst_wr_data", 32'(wr_if.wr_data), 0);
    chk("rst_blocks", 32'(blocks), 0);
    chk("rst_peak", 32'(peak_level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // release: one full redraw
    step(1);
    reset = 1'b0;
    step(30);
    chk("rel_seq_cnt", seq_cnt, 1);
    check_image("rel");

    // peak meter: hold 30 ticks then decay 2 per tick down to 0
    tick(8'd200);
    chk("pk_capture", 32'(peak_level), 200);
    for (int k = 1; k <= 130; k++) begin
      tick(8'd0);
      chk("pk_hold_decay", 32'(peak_level), (k <= 30) ? 200 : ((200 - 2 * (k - 30) > 0) ? 200 - 2 * (k - 30) : 0));
    end
    tick(8'd200);
    for (int k = 0; k < 40; k++) tick(8'd0);
    chk("pk_mid_decay", 32'(peak_level), 180);
    tick(8'd250);
    chk("pk_jump", 32'(peak_level), 250);
    tape_data = 8'd255;
    step(2);
    sample();
    chk("pk_no_tick", 32'(peak_level), 250);
    tape_data = 8'd0;

    // table vectors for the block counter
    vt.push_back('{64, 0, 0});   vt.push_back('{64, 1, 0});
    vt.push_back('{64, 2, 0});   vt.push_back('{64, 3, 0});
    vt.push_back('{64, 4, 1});   vt.push_back('{64, 10, 1});
    vt.push_back('{64, 11, 1});  vt.push_back('{64, 12, 1});
    vt.push_back('{64, 13, 2});  vt.push_back('{64, 13, 2});
    vt.push_back('{64, 5, 0});   vt.push_back('{64, 6, 0});
    vt.push_back('{8, 7, 1});    vt.push_back('{8, 8, 2});
    vt.push_back('{8, 9, 3});    vt.push_back('{3, 10, 4});
    vt.push_back('{32, 11, 4});  vt.push_back('{32, 12, 5});
    vt.push_back('{32, 0, 0});
    foreach (vt[i]) begin
      max = 25'(vt[i].mx);
      pos = 25'(vt[i].p);
      step(4);
      sample();
      chk("tbl_blocks", 32'(blocks), vt[i].exp_blk);
    end
    step(60);
    check_image("tbl");

    // max=160: ten forward changes make one block
    max = 25'd160;
    for (int i = 1; i <= 10; i++) begin
      pos = 25'(i);
      step(4);
      sample();
      if (i == 9) chk("step9_blocks", 32'(blocks), 0);
    end
    chk("step10_blocks", 32'(blocks), 1);
    step(60);
    check_image("step10");

    // saturation then rewind
    for (int i = 0; i < 300; i++) begin
      pos = pos + 25'd1;
      step(2);
    end
    step(60);
    chk("sat_blocks", 32'(blocks), 16);
    check_image("sat");
    pos = 25'd50;
    step(1);
    pos = 25'd20;
    step(4);
    sample();
    chk("rew_blocks", 32'(blocks), 0);
    step(60);
    check_image("rew");

    // first write two cycles after the change
    n0 = seq_cnt;
    c = cyc;
    pos = pos + 25'd1;
    step(40);
    chk("lat_cnt", seq_cnt - n0, 1);
    if (seq_start.size() > n0) chk("lat_start", seq_start[n0], c + 2);

    // five back-to-back changes coalesce into exactly two sequences
    n0 = seq_cnt;
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      pos = pos + 25'd1;
      step(1);
    end
    step(60);
    chk("coal_cnt", seq_cnt - n0, 2);
    if (seq_start.size() > n0 + 1) begin
      chk("coal_start0", seq_start[n0], c + 2);
      chk("coal_start1", seq_start[n0 + 1], c + 2 + NSEG + 4);
    end
    check_image("coal");

    // ena low: counters track, no writes
    max = 25'd16;
    ena = 1'b0;
    n0 = seq_cnt;
    for (int i = 0; i < 6; i++) begin
      pos = pos + 25'd1;
      step(3);
    end
    step(10);
    sample();
    chk("ena0_no_writes", seq_cnt - n0, 0);
    chk("ena0_blocks", 32'(blocks), m_blocks);
    ena = 1'b1;
    step(40);
    chk("ena1_cnt", seq_cnt - n0, 1);
    check_image("ena1");

    // reset in the middle of a sequence
    pos = pos + 25'd1;
    step(8);
    sample();
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    step(1);
    sample();
    chk("abort_wr_ena", 32'(wr_if.wr_ena), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_blocks", 32'(blocks), 0);
    reset = 1'b0;
    step(60);
    check_image("abort");

    // random walk against the model
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(0, 99);
      pv = int'(pos);
      if (r < 60)      pv = pv + $urandom_range(1, 3);
      else if (r < 65) pv = $urandom_range(0, pv);
      pos = 25'(pv);
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: max = 25'd16;
          1: max = 25'd160;
          2: max = 25'd1000;
          default: max = 25'd3;
        endcase
      end
      ena        = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      tape_data  = 8'($urandom);
      step(1);
      sample();
      chk("rnd_blocks", 32'(blocks), m_blocks);
      chk("rnd_peak", 32'(peak_level), m_peak);
    end
    ena = 1'b1;
    frame_tick = 1'b0;
    step(60);
    check_image("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tape_status_seq.md
Name: tape_status_seq

Overview:
- Parametrised successor to the cassette overlay's character-RAM update logic: tracks tape position, keeps an NSEG-segment progress bar, animates two tape gears and runs a peak-hold level meter.
- Emits one character-RAM write per cycle on a single write port; the overlay's dual-port char RAM consumes it on port A.
- Adds rewind detection, exact segment rounding, saturation and coalescing of position changes that arrive mid-sequence.

Parameters:
- POSW, 25, width of pos/max.
- NSEG, 16, progress segments; power of 2, range 2..32.
- ADDRW, 12, char RAM address width.
- BAR_BASE, 136, char RAM address of segment 0.
- GEAR_L_ADDR, 331, left gear cell.
- GEAR_R_ADDR, 340, right gear cell.
- CH_GEAR_A, 8'h2A and CH_GEAR_B, 8'h96, the two gear frames.
- CH_FULL, 8'h7F and CH_EMPTY, 8'hA6, the bar cells.
- HOLD_FRAMES, 30, peak hold time in frames.
- DECAY, 2, peak decay per frame after hold.

Ports:
- i_clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- ena, in, 1, overlay enabled; when low, no sequences start, but counters still track.
- max, in, POSW, tape length.
- pos, in, POSW, current tape position.
- tape_data, in, 8, instantaneous level sample.
- frame_tick, in, 1, one-cycle pulse per frame (vcnt==0).
- wr_ena, out, 1, char RAM write strobe.
- wr_addr, out, ADDRW, write address.
- wr_data, out, 8, character code.
- blocks, out, $clog2(NSEG)+1, filled segment count, 0..NSEG.
- peak_level, out, 8, held/decayed level for the meter bar.
- busy, out, 1, sequencer not in IDLE.

Behaviour:
- Reset values: wr_ena=0, wr_addr=0, wr_data=0, blocks=0, peak_level=0, busy=0, inc_pos=0, gear_phase=0, hold counter=0, pos_r=0, state=IDLE.
- Reset also sets dirty=1, so one full redraw follows reset. Reset mid-sequence aborts it immediately, with no partial write completed.
- pos_r<=pos every cycle; a change is pos!=pos_r.
- increment = max>>log2(NSEG); all widths POSW.
- Forward change (pos>pos_r): inc_pos+1. When inc_pos+1>=increment, inc_pos<=0 and blocks<=min(blocks+1,NSEG). With increment==0, every change adds a block (saturating).
- Rewind change (pos<pos_r) or pos==0: inc_pos<=0, blocks<=0. Rewind takes priority over the forward step.
- Any change: dirty<=1 and gear_phase toggles.
- FSM states: IDLE, GEAR_L, GEAR_R, BAR, GAP.
  - IDLE: if dirty&ena, clear dirty and go to GEAR_L.
  - GEAR_L: write GEAR_L_ADDR with gear_phase ? CH_GEAR_A : CH_GEAR_B.
  - GEAR_R: write GEAR_R_ADDR with the opposite code.
  - BAR: seg from 0 to NSEG-1, one per cycle; write BAR_BASE+seg with seg<blocks ? CH_FULL : CH_EMPTY. blocks is sampled into a snapshot at GEAR_L entry, so a sequence is self-consistent.
  - GAP: one idle cycle, then IDLE.
- Outputs are registered. The first wr_ena appears 2 cycles after the cycle in which pos!=pos_r. There are exactly NSEG+2 consecutive wr_ena cycles per sequence.
- Changes during a sequence set dirty and coalesce into exactly one follow-up sequence, starting 2 cycles after GAP.
- Peak meter, on frame_tick only:
  - If tape_data>=peak_level: peak_level<=tape_data and hold<=HOLD_FRAMES.
  - Else if hold!=0: hold decrements.
  - Else peak_level<=sat_sub(peak_level,DECAY), floored at 0.
- busy is high from GEAR_L through GAP.

Decomposition:
- Package tape_ovl_pkg: FSM state enum; default char-code constants; function sat_sub8.
- One sub-module, tape_peak_meter (peak/hold/decay, 8-bit), instanced once. The remaining logic lives in the top.

Test Plan:
- Reset release with ena=1 -> 18 consecutive writes: 331=96, 340=2A, addresses 136..151 all A6; blocks=0.
- max=160 (increment 10), pos stepped 1..10 with 4-cycle spacing -> blocks=1 after the 10th change. The final sequence writes 136=7F and 137..151=A6, with gear codes alternating per sequence.
- pos stepped forward 300 times with max=160 -> blocks saturates at 16 and all 16 cells are 7F. Then pos 50->20 -> blocks=0 and all cells A6.
- pos changes on 5 consecutive cycles -> exactly two sequences, the second starting 2 cycles after the first GAP; no overlapping writes.
- Peak meter with tape_data=200 on one tick, then 0:
  - peak_level holds 200 for 30 ticks, then reads 198, 196, …, reaching 0 after 100 more ticks.
  - tape_data=250 mid-decay -> peak_level jumps to 250 immediately.
- ena=0 while pos changes -> no wr_ena, but blocks still updates. On ena=1 -> one sequence reflects the current blocks.
